// File: rtl/control_unit.sv
// Single-cycle MIPS main decoder and ALU decoder, with a sticky illegal-instruction flag for debug.
// All control outputs are combinational and are forced low while rst_n is asserted.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       branch,
  output logic       memtoreg,
  output logic       memwrite,
  output logic       pcsrc,
  output logic       alusrc,
  output logic       regdst,
  output logic       regwrite,
  output logic       jump,
  output logic [2:0] alucontrol,
  output logic       dec_branch,
  output logic       illegal,
  output logic       illegal_seen
);

  localparam int unsigned OP_W   = 6;
  localparam int unsigned ALUC_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(3'b000);
  localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3'b001);
  localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(3'b010);
  localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(3'b110);
  localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(3'b111);

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  aluop_e            aluop;
  logic              op_bad;
  logic              funct_bad;
  logic              memtoreg_d;
  logic              memwrite_d;
  logic              alusrc_d;
  logic              regdst_d;
  logic              regwrite_d;
  logic              jump_d;
  logic              dec_branch_d;
  logic [ALUC_W-1:0] aluctl_d;

  // Main decode; unknown or unsupported opcodes take the default all-zero path.
  always_comb begin
    memtoreg_d   = 1'b0;
    memwrite_d   = 1'b0;
    alusrc_d     = 1'b0;
    regdst_d     = 1'b0;
    regwrite_d   = 1'b0;
    jump_d       = 1'b0;
    dec_branch_d = 1'b0;
    aluop        = ALUOP_ADD;
    op_bad       = 1'b0;
    case (op)
      OP_RTYPE: begin
        regwrite_d = 1'b1;
        regdst_d   = 1'b1;
        aluop      = ALUOP_FUNCT;
      end
      OP_LW: begin
        regwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        memtoreg_d = 1'b1;
      end
      OP_SW: begin
        memwrite_d = 1'b1;
        alusrc_d   = 1'b1;
      end
      OP_BEQ: begin
        dec_branch_d = 1'b1;
        aluop        = ALUOP_SUB;
      end
      OP_ADDI: begin
        regwrite_d = 1'b1;
        alusrc_d   = 1'b1;
      end
      OP_J:    jump_d = 1'b1;
      default: op_bad = 1'b1;
    endcase
  end

  // ALU decode; an unsupported R-type funct is flagged so writeback can be suppressed.
  always_comb begin
    aluctl_d  = ALU_AND;
    funct_bad = 1'b0;
    case (aluop)
      ALUOP_ADD: aluctl_d = ALU_ADD;
      ALUOP_SUB: aluctl_d = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          6'b100000: aluctl_d = ALU_ADD;
          6'b100010: aluctl_d = ALU_SUB;
          6'b100100: aluctl_d = ALU_AND;
          6'b100101: aluctl_d = ALU_OR;
          6'b101010: aluctl_d = ALU_SLT;
          default:   funct_bad = 1'b1;
        endcase
      end
      default: aluctl_d = ALU_AND;
    endcase
  end

  // Output gating: everything is held at zero while reset is asserted.
  always_comb begin
    memtoreg   = 1'b0;
    memwrite   = 1'b0;
    pcsrc      = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    jump       = 1'b0;
    alucontrol = ALU_AND;
    dec_branch = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      memtoreg   = memtoreg_d;
      memwrite   = memwrite_d;
      pcsrc      = branch & zero;
      alusrc     = alusrc_d;
      regdst     = regdst_d;
      regwrite   = regwrite_d & ~funct_bad;
      jump       = jump_d;
      alucontrol = (op_bad | funct_bad) ? ALU_AND : aluctl_d;
      dec_branch = dec_branch_d;
      illegal    = op_bad | funct_bad;
    end
  end

  // Sticky debug flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen <= 1'b0;
    end else if (illegal) begin
      illegal_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: decode vectors, pcsrc sweep,
// sticky illegal flag, X on opcode and asynchronous reset behaviour.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] op = 6'b000000;
  logic [5:0] funct = 6'b000000;
  logic       zero = 1'b0;
  logic       branch = 1'b0;
  logic       memtoreg, memwrite, pcsrc, alusrc, regdst, regwrite, jump;
  logic [2:0] alucontrol;
  logic       dec_branch, illegal, illegal_seen;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .funct        (funct),
    .zero         (zero),
    .branch       (branch),
    .memtoreg     (memtoreg),
    .memwrite     (memwrite),
    .pcsrc        (pcsrc),
    .alusrc       (alusrc),
    .regdst       (regdst),
    .regwrite     (regwrite),
    .jump         (jump),
    .alucontrol   (alucontrol),
    .dec_branch   (dec_branch),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a new instruction mid-cycle and let the combinational decode settle.
  task automatic apply(input logic [5:0] o, input logic [5:0] f);
    op    = o;
    funct = f;
    #1;
  endtask

  initial begin
    logic [1:0] bz;
    logic [3:0] pc_exp;
    pc_exp = 4'b1000;

    // Reset asserted with a live R-type and a taken branch: everything low.
    rst_n = 1'b0;
    branch = 1'b1;
    zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pcsrc", 8'(pcsrc), 8'd0);
    chk("rst_regwrite", 8'(regwrite), 8'd0);
    chk("rst_regdst", 8'(regdst), 8'd0);
    chk("rst_illegal_seen", 8'(illegal_seen), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // pcsrc sweep under two different opcodes.
    for (int k = 0; k < 2; k++) begin
      apply((k == 0) ? 6'b100011 : 6'b000010, 6'b000000);
      for (int i = 0; i < 4; i++) begin
        bz = 2'(i);
        branch = bz[1];
        zero   = bz[0];
        #10;
        chk($sformatf("pcsrc_op%0d_bz%0d", k, i), 8'(pcsrc), 8'(pc_exp[i]));
      end
    end
    branch = 1'b0;
    zero = 1'b0;

    // R-type sub.
    apply(6'b000000, 6'b100010);
    chk("sub_regwrite", 8'(regwrite), 8'd1);
    chk("sub_regdst", 8'(regdst), 8'd1);
    chk("sub_alusrc", 8'(alusrc), 8'd0);
    chk("sub_aluctl", 8'(alucontrol), 8'h06);
    chk("sub_illegal", 8'(illegal), 8'd0);

    // Other R-type functs.
    apply(6'b000000, 6'b100000); chk("add_aluctl", 8'(alucontrol), 8'h02);
    apply(6'b000000, 6'b100100); chk("and_aluctl", 8'(alucontrol), 8'h00);
    apply(6'b000000, 6'b100101); chk("or_aluctl", 8'(alucontrol), 8'h01);
    apply(6'b000000, 6'b101010); chk("slt_aluctl", 8'(alucontrol), 8'h07);
    chk("slt_regwrite", 8'(regwrite), 8'd1);

    // lw / sw / addi.
    apply(6'b100011, 6'b000000);
    chk("lw_regwrite", 8'(regwrite), 8'd1);
    chk("lw_alusrc", 8'(alusrc), 8'd1);
    chk("lw_memtoreg", 8'(memtoreg), 8'd1);
    chk("lw_aluctl", 8'(alucontrol), 8'h02);
    chk("lw_regdst", 8'(regdst), 8'd0);
    apply(6'b101011, 6'b000000);
    chk("sw_memwrite", 8'(memwrite), 8'd1);
    chk("sw_regwrite", 8'(regwrite), 8'd0);
    chk("sw_alusrc", 8'(alusrc), 8'd1);
    apply(6'b001000, 6'b000000);
    chk("addi_regwrite", 8'(regwrite), 8'd1);
    chk("addi_alusrc", 8'(alusrc), 8'd1);
    chk("addi_memtoreg", 8'(memtoreg), 8'd0);
    chk("addi_aluctl", 8'(alucontrol), 8'h02);

    // beq / j.
    apply(6'b000100, 6'b000000);
    chk("beq_dec_branch", 8'(dec_branch), 8'd1);
    chk("beq_aluctl", 8'(alucontrol), 8'h06);
    chk("beq_regwrite", 8'(regwrite), 8'd0);
    apply(6'b000010, 6'b000000);
    chk("j_jump", 8'(jump), 8'd1);
    chk("j_others", 8'({regwrite, memwrite, memtoreg, alusrc, regdst, dec_branch}), 8'd0);
    chk("j_illegal", 8'(illegal), 8'd0);

    // Sticky flag still clear after only legal instructions.
    @(posedge clk);
    #1;
    chk("seen_clear", 8'(illegal_seen), 8'd0);

    // Illegal opcode, then one edge.
    @(negedge clk);
    apply(6'b111111, 6'b000000);
    chk("ill_illegal", 8'(illegal), 8'd1);
    chk("ill_controls", 8'({regwrite, memwrite, memtoreg, alusrc, regdst, jump, dec_branch}), 8'd0);
    chk("ill_aluctl", 8'(alucontrol), 8'h00);
    chk("ill_seen_pre", 8'(illegal_seen), 8'd0);
    @(posedge clk);
    #1;
    chk("ill_seen_post", 8'(illegal_seen), 8'd1);
    apply(6'b000000, 6'b100000);
    chk("legal_after_illegal", 8'(illegal), 8'd0);
    @(posedge clk);
    #1;
    chk("seen_sticky", 8'(illegal_seen), 8'd1);

    // Unsupported R-type funct.
    apply(6'b000000, 6'b000111);
    chk("badfunct_illegal", 8'(illegal), 8'd1);
    chk("badfunct_regwrite", 8'(regwrite), 8'd0);
    chk("badfunct_aluctl", 8'(alucontrol), 8'h00);

    // Unknown opcode: illegal path, pcsrc unaffected.
    branch = 1'b1;
    zero = 1'b1;
    apply(6'bxxxxxx, 6'bxxxxxx);
    chk("x_pcsrc", 8'(pcsrc), 8'd1);
    chk("x_illegal", 8'(illegal), 8'd1);
    chk("x_regwrite", 8'(regwrite), 8'd0);

    // Asynchronous reset mid-cycle with a live R-type and taken branch.
    apply(6'b000000, 6'b100000);
    chk("pre_rst_regwrite", 8'(regwrite), 8'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pcsrc", 8'(pcsrc), 8'd0);
    chk("arst_regwrite", 8'(regwrite), 8'd0);
    chk("arst_illegal_seen", 8'(illegal_seen), 8'd0);
    chk("arst_aluctl", 8'(alucontrol), 8'h00);
    #4;
    rst_n = 1'b1;
    #1;
    chk("resume_regwrite", 8'(regwrite), 8'd1);
    chk("resume_pcsrc", 8'(pcsrc), 8'd1);
    chk("resume_aluctl", 8'(alucontrol), 8'h02);
    @(posedge clk);
    #1;
    chk("resume_seen", 8'(illegal_seen), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
